// File: rtl/bin_to_ascii_seq_pkg.sv
// Shared definitions for the binary-to-decimal-ASCII converter.
//   ASCII_ZERO / ASCII_SPACE / ASCII_DASH : character codes used by the formatter
//   state_t                               : 2-bit FSM encoding (IDLE, SHIFT, FORMAT, DONE)
//   bcd_add3                              : double-dabble digit correction
package bin_to_ascii_seq_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2,
        DONE   = 2'd3
    } state_t;

    // A digit of 5 or more would become >= 10 after the next left shift,
    // so pre-add 3 to make the shift carry into the next digit instead.
    function automatic logic [3:0] bcd_add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? (digit + 4'd3) : digit;
    endfunction

endpackage

// File: rtl/bin_to_ascii_seq_bcd_digit_to_ascii.sv
// One BCD digit to one ASCII character.
//   digit : BCD digit 0..9
//   blank : show this digit as a space (leading zero)
//   ovf   : conversion overflowed, show a dash
//   ascii : resulting character
module bcd_digit_to_ascii
    import bin_to_ascii_seq_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       ovf,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_ZERO + {4'b0000, digit};
        if (ovf) begin
            ascii = ASCII_DASH;
        end else if (blank) begin
            ascii = ASCII_SPACE;
        end
    end

endmodule

// File: rtl/bin_to_ascii_seq.sv
// Sequential binary to fixed-width decimal ASCII converter (double dabble,
// one input bit per cycle).
//   clk, reset  : clock, asynchronous active-high reset
//   start       : conversion request, sampled only while idle
//   binInput    : unsigned value captured when start is accepted
//   busy        : conversion in progress (SHIFT, FORMAT, DONE)
//   done        : one-cycle pulse, result outputs just updated
//   overflow    : value did not fit in BCD_NUMBER_LENGTH digits
//   bcdOutput   : BCD digits, digit 0 in [3:0]
//   asciiOutput : ASCII string, least-significant digit in [7:0]
//   fsm_state   : current FSM state for observation
//
// Handshake: start is accepted on a rising edge where the FSM is IDLE and
// start=1; busy rises the cycle after and stays high until the done cycle
// ends. start seen while busy is dropped, not queued. Result outputs change
// only in the cycle done is high and hold until the next completed
// conversion.
module bin_to_ascii_seq
    import bin_to_ascii_seq_pkg::*;
#(
    parameter int BIN_WIDTH         = 10,
    parameter int BCD_NUMBER_LENGTH = 3,
    parameter int BLANK_LEADING     = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [BIN_WIDTH-1:0]           binInput,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic [4*BCD_NUMBER_LENGTH-1:0] bcdOutput,
    output logic [8*BCD_NUMBER_LENGTH-1:0] asciiOutput,
    output logic [1:0]                     fsm_state
);

    localparam int N  = BCD_NUMBER_LENGTH;
    localparam int W  = BIN_WIDTH;
    localparam int CW = $clog2(W + 1);

    // Idle display: every digit '0', or blanks with a '0' in the units place.
    function automatic logic [8*N-1:0] ascii_reset_value();
        logic [8*N-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[8*i +: 8] = ((BLANK_LEADING != 0) && (i != 0)) ? ASCII_SPACE : ASCII_ZERO;
        end
        return v;
    endfunction

    localparam logic [8*N-1:0] ASCII_RESET = ascii_reset_value();

    state_t         state, state_next;
    logic [W-1:0]   bin_q;
    logic [4*N-1:0] bcd_q;
    logic           ovf_q;
    logic [CW-1:0]  cnt_q;

    logic [4*N-1:0] bcd_adj;
    logic [4*N-1:0] bcd_shifted;
    logic           shift_out;
    logic [N-1:0]   blank;
    logic           leading;
    logic [8*N-1:0] ascii_fmt;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_next = FORMAT;
            FORMAT:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign fsm_state = state;

    // ---------------- double-dabble step ----------------
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < N; i++) begin
            bcd_adj[4*i +: 4] = bcd_add3(bcd_q[4*i +: 4]);
        end
    end

    // The bit leaving the top digit is a decimal carry past the last digit.
    assign {shift_out, bcd_shifted} = {bcd_adj, bin_q[W-1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q <= '0;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_q <= binInput;
                        bcd_q <= '0;
                        ovf_q <= 1'b0;
                        cnt_q <= CW'(W);
                    end
                end
                SHIFT: begin
                    bin_q <= bin_q << 1;
                    bcd_q <= bcd_shifted;
                    ovf_q <= ovf_q | shift_out;
                    cnt_q <= cnt_q - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // ---------------- formatting ----------------
    // A digit is blanked while every digit above it (and itself) is zero.
    always_comb begin
        blank   = '0;
        leading = 1'b1;
        for (int i = N - 1; i >= 1; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) leading = 1'b0;
            blank[i] = leading && (BLANK_LEADING != 0);
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_digit
        bcd_digit_to_ascii u_digit (
            .digit (bcd_q[4*g +: 4]),
            .blank (blank[g]),
            .ovf   (ovf_q),
            .ascii (ascii_fmt[8*g +: 8])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow    <= 1'b0;
            bcdOutput   <= '0;
            asciiOutput <= ASCII_RESET;
        end else if (state == FORMAT) begin
            overflow    <= ovf_q;
            bcdOutput   <= bcd_q;
            asciiOutput <= ascii_fmt;
        end
    end

endmodule

// File: tb/tb_bin_to_ascii_seq.sv
module tb_bin_to_ascii_seq;

  localparam int W = 10;
  localparam int N = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [W-1:0] bin_input;

  always #5 clk = ~clk;

  logic          busy_b, done_b, ovf_b;
  logic [4*N-1:0] bcd_b;
  logic [8*N-1:0] ascii_b;
  logic [1:0]    st_b;
  logic          busy_z, done_z, ovf_z;
  logic [4*N-1:0] bcd_z;
  logic [8*N-1:0] ascii_z;
  logic [1:0]    st_z;

  bin_to_ascii_seq #(.BIN_WIDTH(W), .BCD_NUMBER_LENGTH(N), .BLANK_LEADING(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .binInput(bin_input),
    .busy(busy_b), .done(done_b), .overflow(ovf_b),
    .bcdOutput(bcd_b), .asciiOutput(ascii_b), .fsm_state(st_b)
  );

  bin_to_ascii_seq #(.BIN_WIDTH(W), .BCD_NUMBER_LENGTH(N), .BLANK_LEADING(0)) dut_z (
    .clk(clk), .reset(reset), .start(start), .binInput(bin_input),
    .busy(busy_z), .done(done_z), .overflow(ovf_z),
    .bcdOutput(bcd_z), .asciiOutput(ascii_z), .fsm_state(st_z)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [8*N-1:0] exp_q[$];
  logic [8*N-1:0] last_b;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: the decimal text of v, right-justified in three columns,
  // space-padded or zero-padded; dashes when it needs a fourth column.
  function automatic logic [8*N-1:0] model_ascii(input int v, input bit blank);
    string s;
    if (v > 999) return 24'h2D2D2D;
    s = blank ? $sformatf("%3d", v) : $sformatf("%03d", v);
    return {s[0], s[1], s[2]};
  endfunction

  // Reference: low three decimal digits of v, one per nibble.
  function automatic logic [4*N-1:0] model_bcd(input int v);
    int r;
    r = v % 1000;
    return {4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  // ---------------- driver ----------------
  // Requests one conversion from idle and checks timing plus both results.
  task automatic convert(input int v);
    bit seen;
    int lat;
    seen = 0;
    lat  = 0;
    @(negedge clk);
    start     = 1'b1;
    bin_input = W'(v);
    exp_q.push_back(model_ascii(v, 1'b1));
    @(posedge clk);  // accepting edge
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      start     = 1'b0;
      bin_input = W'($urandom_range(0, 1023));
      check("busy", {31'd0, busy_b}, 32'd1);
      if (c == 3) check("hold", {8'd0, ascii_b}, {8'd0, last_b});
      if (done_b) begin
        seen = 1;
        lat  = c;
      end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", lat, W + 2);
      check("ascii_blank", {8'd0, ascii_b}, {8'd0, exp_q.pop_front()});
      check("ascii_zero", {8'd0, ascii_z}, {8'd0, model_ascii(v, 1'b0)});
      check("bcd", {20'd0, bcd_b}, {20'd0, model_bcd(v)});
      check("overflow", {31'd0, ovf_b}, {31'd0, v > 999});
      check("done_z", {31'd0, done_z}, 32'd1);
      last_b = model_ascii(v, 1'b1);
      @(negedge clk);
      check("done_pulse", {31'd0, done_b}, 32'd0);
      check("idle_busy", {31'd0, busy_b}, 32'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, {31'd0, busy_b}, 32'd0);
    check({tag, "_done"}, {31'd0, done_b}, 32'd0);
    check({tag, "_ovf"}, {31'd0, ovf_b}, 32'd0);
    check({tag, "_bcd"}, {20'd0, bcd_b}, 32'd0);
    check({tag, "_ascii_b"}, {8'd0, ascii_b}, 32'h202030);
    check({tag, "_ascii_z"}, {8'd0, ascii_z}, 32'h303030);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    int v;
    reset     = 1'b1;
    start     = 1'b0;
    bin_input = '0;
    last_b    = 24'h202030;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // directed values
    convert(0);
    check("lit_0", {8'd0, ascii_b}, 32'h202030);
    convert(255);
    check("lit_255", {8'd0, ascii_b}, 32'h323535);
    check("lit_255_bcd", {20'd0, bcd_b}, 32'h255);
    convert(7);
    convert(40);
    convert(1000);
    check("lit_1000", {8'd0, ascii_b}, 32'h2D2D2D);
    check("lit_1000_ovf", {31'd0, ovf_b}, 32'd1);
    convert(999);
    check("lit_999", {8'd0, ascii_b}, 32'h393939);
    check("lit_999_ovf", {31'd0, ovf_b}, 32'd0);
    convert(5);
    check("lit_5_zero", {8'd0, ascii_z}, 32'h303035);

    // start re-pulsed mid-conversion is ignored
    @(negedge clk);
    start     = 1'b1;
    bin_input = W'(123);
    exp_q.push_back(model_ascii(123, 1'b1));
    @(posedge clk);
    dones = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start     = (c == 3);
      bin_input = W'(456);
      if (dones == 0) check("retrig_busy", {31'd0, busy_b}, 32'd1);
      if (done_b) begin
        dones++;
        check("retrig_ascii", {8'd0, ascii_b}, {8'd0, exp_q.pop_front()});
      end
    end
    start = 1'b0;
    check("retrig_dones", dones, 1);
    last_b = model_ascii(123, 1'b1);

    // reset in the middle of SHIFT aborts the conversion
    convert(987);
    @(negedge clk);
    start     = 1'b1;
    bin_input = W'(777);
    @(posedge clk);
    repeat (4) @(negedge clk);
    start = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_values("abort");
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (done_b || done_z) dones++;
    end
    check("abort_no_done", dones, 0);
    last_b = 24'h202030;
    convert(321);

    // full sweep of the input range on both instances
    for (int i = 0; i < 1024; i++) convert(i);

    // random values
    for (int i = 0; i < 60; i++) begin
      v = $urandom_range(0, 1023);
      convert(v);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
